// File: rtl/hdmi_mon_pkg.sv
// Shared types, constants and the per-beat CRC-32 helper for the HDMI stream monitor.
package hdmi_mon_pkg;

  typedef enum logic [0:0] {
    SEEK_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Reflected CRC-32 over one RGB888 beat, bytes taken low to high.
  function automatic logic [31:0] crc32_update24(input logic [31:0] crc,
                                                 input logic [23:0] data);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 3; b++) begin
      c = c ^ {24'd0, data[b*8 +: 8]};
      for (int i = 0; i < 8; i++) begin
        c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/hdmi_throttle_lfsr.sv
// Galois LFSR that optionally gates the sink's registered tready for backpressure testing.
module hdmi_throttle_lfsr
  import hdmi_mon_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic throttle_en,
  output logic tready
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        tready_q, tready_d;

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    tready_d = throttle_en ? lfsr_q[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= LFSR_SEED;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      tready_q <= tready_d;
    end
  end

  assign tready = tready_q;

endmodule

// File: rtl/hdmi_stream_monitor.sv
// AXI4-Stream RGB888 video sink: tracks frame position, per-frame CRC-32 and framing errors.
module hdmi_stream_monitor
  import hdmi_mon_pkg::*;
#(
  parameter int          SCREEN_WIDTH  = 32,
  parameter int          SCREEN_HEIGHT = 24,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic        throttle_en,
  input  logic        clear_err,
  output logic [31:0] beat_count,
  output logic [31:0] frame_count,
  output logic [31:0] crc_last,
  output logic [15:0] line_count,
  output logic [15:0] pixel_in_line,
  output logic        frame_done,
  output logic [15:0] err_sof_count,
  output logic [15:0] err_eol_count,
  output logic        err_sticky
);

  localparam logic [15:0] LAST_PIX  = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] LAST_LINE = 16'(SCREEN_HEIGHT - 1);

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high.
  logic tready;

  hdmi_throttle_lfsr #(.LFSR_SEED(LFSR_SEED)) u_throttle (
    .clk         (clk),
    .rst         (rst),
    .throttle_en (throttle_en),
    .tready      (tready)
  );

  state_e      state_q, state_d;
  logic [31:0] crc_acc_q, crc_acc_d;
  logic [15:0] line_q, line_d, pixel_q, pixel_d;
  logic        frame_bad_q, frame_bad_d;
  logic [31:0] beat_count_q, beat_count_d, frame_count_q, frame_count_d;
  logic [31:0] crc_last_q, crc_last_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic        err_sticky_q, err_sticky_d;

  logic        accept, sof_err, eol_err, last_pix, last_line;
  logic [31:0] crc_next, crc_first;
  logic [15:0] sof_base, eol_base;

  always_comb begin
    state_d       = state_q;
    crc_acc_d     = crc_acc_q;
    line_d        = line_q;
    pixel_d       = pixel_q;
    frame_bad_d   = frame_bad_q;
    beat_count_d  = beat_count_q;
    frame_count_d = frame_count_q;
    crc_last_d    = crc_last_q;
    frame_done_d  = 1'b0;
    sof_err       = 1'b0;
    eol_err       = 1'b0;

    accept    = s_axis_tvalid & tready;
    crc_next  = crc32_update24(crc_acc_q, s_axis_tdata);
    crc_first = crc32_update24(CRC32_INIT, s_axis_tdata);
    last_pix  = (pixel_q == LAST_PIX);
    last_line = (line_q == LAST_LINE);

    if (accept) begin
      beat_count_d = beat_count_q + 32'd1;
      if (s_axis_tuser) begin
        // A start-of-frame always (re)starts a frame; mid-frame it also aborts the old one.
        sof_err     = (state_q == IN_FRAME);
        state_d     = IN_FRAME;
        crc_acc_d   = crc_first;
        line_d      = 16'd0;
        pixel_d     = 16'd1;
        frame_bad_d = 1'b0;
      end else if (state_q == IN_FRAME) begin
        crc_acc_d = crc_next;
        if (last_line && last_pix) begin
          if (!frame_bad_q) begin
            crc_last_d    = ~crc_next;
            frame_count_d = frame_count_q + 32'd1;
            frame_done_d  = 1'b1;
          end
          state_d   = SEEK_SOF;
          crc_acc_d = CRC32_INIT;
          line_d    = 16'd0;
          pixel_d   = 16'd0;
        end else begin
          eol_err = (s_axis_tlast != last_pix);
          if (s_axis_tlast || last_pix) begin
            line_d  = line_q + 16'd1;
            pixel_d = 16'd0;
          end else begin
            pixel_d = pixel_q + 16'd1;
          end
          frame_bad_d = frame_bad_q | eol_err;
        end
      end
    end

    // clear_err wins over the stored count, but a coincident new error still lands as 1.
    sof_base     = clear_err ? 16'd0 : err_sof_q;
    eol_base     = clear_err ? 16'd0 : err_eol_q;
    err_sof_d    = (sof_err && sof_base != 16'hFFFF) ? sof_base + 16'd1 : sof_base;
    err_eol_d    = (eol_err && eol_base != 16'hFFFF) ? eol_base + 16'd1 : eol_base;
    err_sticky_d = (clear_err ? 1'b0 : err_sticky_q) | sof_err | eol_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEEK_SOF;
      crc_acc_q     <= CRC32_INIT;
      line_q        <= 16'd0;
      pixel_q       <= 16'd0;
      frame_bad_q   <= 1'b0;
      beat_count_q  <= 32'd0;
      frame_count_q <= 32'd0;
      crc_last_q    <= 32'd0;
      frame_done_q  <= 1'b0;
      err_sof_q     <= 16'd0;
      err_eol_q     <= 16'd0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_acc_q     <= crc_acc_d;
      line_q        <= line_d;
      pixel_q       <= pixel_d;
      frame_bad_q   <= frame_bad_d;
      beat_count_q  <= beat_count_d;
      frame_count_q <= frame_count_d;
      crc_last_q    <= crc_last_d;
      frame_done_q  <= frame_done_d;
      err_sof_q     <= err_sof_d;
      err_eol_q     <= err_eol_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign s_axis_tready = tready;
  assign beat_count    = beat_count_q;
  assign frame_count   = frame_count_q;
  assign crc_last      = crc_last_q;
  assign line_count    = line_q;
  assign pixel_in_line = pixel_q;
  assign frame_done    = frame_done_q;
  assign err_sof_count = err_sof_q;
  assign err_eol_count = err_eol_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_hdmi_stream_monitor.sv
// Self-checking bench for hdmi_stream_monitor: table of frame scenarios, hand sequences, random frames.
module tb_hdmi_stream_monitor;

  localparam int W = 32;
  localparam int H = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tready;
  logic        throttle_en = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] beat_count, frame_count, crc_last;
  logic [15:0] line_count, pixel_in_line, err_sof_count, err_eol_count;
  logic        frame_done, err_sticky;

  hdmi_stream_monitor #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .LFSR_SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .throttle_en   (throttle_en),
    .clear_err     (clear_err),
    .beat_count    (beat_count),
    .frame_count   (frame_count),
    .crc_last      (crc_last),
    .line_count    (line_count),
    .pixel_in_line (pixel_in_line),
    .frame_done    (frame_done),
    .err_sof_count (err_sof_count),
    .err_eol_count (err_eol_count),
    .err_sticky    (err_sticky)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit stuck  = 1'b0;
  bit gaps   = 1'b0;
  int n_sent = 0;
  int done_pulses = 0;

  always @(negedge clk) begin
    if (rst) done_pulses = 0;
    else if (frame_done) done_pulses++;
  end

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];
  logic [31:0] exp_beats, exp_frames, exp_crc;
  int          exp_sof, exp_eol;
  bit          exp_sticky;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[(c[7:0] ^ b)] ^ (c >> 8);
  endfunction

  task automatic model_reset();
    exp_beats = 0; exp_frames = 0; exp_crc = 0;
    exp_sof = 0; exp_eol = 0; exp_sticky = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [23:0] d, input bit u, input bit l);
    int guard;
    if (stuck) return;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL tready_timeout actual=0 required=1");
        stuck = 1'b1;
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    n_sent++;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Sends one frame (optionally truncated / with one short line); returns the zlib CRC of the bytes sent.
  task automatic send_frame(input bit rnd, input int short_line, input int short_pix,
                            input int stop_after, input bit clr_first, output logic [31:0] crc_out);
    logic [31:0] c;
    logic [23:0] d;
    int  n;
    bit  done, last, is_short;
    c = 32'hFFFFFFFF; n = 0; done = 1'b0;
    for (int ln = 0; ln < H && !done; ln++) begin
      for (int px = 0; px < W && !done; px++) begin
        is_short = (ln == short_line) && (px == short_pix);
        last = (px == W - 1) || is_short;
        d = rnd ? 24'($urandom) : 24'(n);
        if (clr_first && n == 0) clear_err = 1'b1;
        send_beat(d, n == 0, last);
        clear_err = 1'b0;
        for (int b = 0; b < 3; b++) c = crc_byte(c, d[b*8 +: 8]);
        n++;
        if (stop_after > 0 && n >= stop_after) done = 1'b1;
        if (is_short) break;
      end
    end
    crc_out = ~c;
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_beat(24'($urandom), 1'b0, 1'($urandom));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_state(input string tag);
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".beat_count"},  beat_count,  exp_beats);
    check({tag, ".frame_count"}, frame_count, exp_frames);
    check({tag, ".crc_last"},    crc_last,    exp_crc);
    check({tag, ".err_sof"},     {16'd0, err_sof_count}, 32'(exp_sof));
    check({tag, ".err_eol"},     {16'd0, err_eol_count}, 32'(exp_eol));
    check({tag, ".err_sticky"},  {31'd0, err_sticky},    {31'd0, exp_sticky});
    check({tag, ".done_pulses"}, 32'(done_pulses), exp_frames);
    check({tag, ".line_pixel"},  {line_count, pixel_in_line}, 32'd0);
  endtask

  typedef struct {
    int junk;
    int abort_at;
    int short_line;
    int short_pix;
    bit throttle;
    int d_beats;
    int d_frames;
    int d_sof;
    int d_eol;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] c, dummy;
    int kind, s0;

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end

    vecs[0] = '{0,  0,   -1, -1, 1'b0, 768, 1, 0, 0};
    vecs[1] = '{0,  0,   -1, -1, 1'b1, 768, 1, 0, 0};
    vecs[2] = '{10, 0,   -1, -1, 1'b0, 778, 1, 0, 0};
    vecs[3] = '{0,  100, -1, -1, 1'b0, 868, 1, 1, 0};
    vecs[4] = '{0,  0,    3, 10, 1'b0, 747, 0, 0, 1};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst.beat_count", beat_count, 32'd0);
    check("rst.crc_last", crc_last, 32'd0);
    check("rst.frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.tready", {31'd0, s_axis_tready}, 32'd1);

    // Table-driven frame scenarios (deterministic pixel-index data)
    for (int i = 0; i < 5; i++) begin
      throttle_en = vecs[i].throttle;
      send_junk(vecs[i].junk);
      if (vecs[i].abort_at > 0) send_frame(1'b0, -1, -1, vecs[i].abort_at, 1'b0, dummy);
      send_frame(1'b0, vecs[i].short_line, vecs[i].short_pix, 0, 1'b0, c);
      exp_beats  += 32'(vecs[i].d_beats);
      exp_frames += 32'(vecs[i].d_frames);
      exp_sof    += vecs[i].d_sof;
      exp_eol    += vecs[i].d_eol;
      if (vecs[i].d_sof + vecs[i].d_eol > 0) exp_sticky = 1'b1;
      if (vecs[i].d_frames > 0) exp_crc = c;
      check_state($sformatf("vec%0d", i));
    end
    throttle_en = 1'b0;

    // clear_err pulse
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    exp_sof = 0; exp_eol = 0; exp_sticky = 1'b0;
    check_state("clear");

    // clear_err coinciding with a new SOF error: clear wins, new error counts from zero
    send_frame(1'b0, -1, -1, 5, 1'b0, dummy);
    send_frame(1'b0, -1, -1, 5, 1'b0, dummy);
    send_frame(1'b0, -1, -1, 0, 1'b1, c);
    exp_beats += 32'd778; exp_frames += 1; exp_crc = c;
    exp_sof = 1; exp_eol = 0; exp_sticky = 1'b1;
    check_state("clear_vs_err");

    // Reset mid-frame
    send_frame(1'b0, -1, -1, 400, 1'b0, dummy);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.tready", {31'd0, s_axis_tready}, 32'd0);
    check("midrst.beat_count", beat_count, 32'd0);
    check("midrst.frame_count", frame_count, 32'd0);
    check("midrst.errs", {err_sof_count, err_eol_count}, 32'd0);
    check("midrst.line_pixel", {line_count, pixel_in_line}, 32'd0);
    check("midrst.sticky", {31'd0, err_sticky}, 32'd0);
    rst = 1'b0;
    model_reset();
    send_frame(1'b0, -1, -1, 0, 1'b0, c);
    exp_beats = 768; exp_frames = 1; exp_crc = c;
    check_state("after_rst");

    // Randomized frames with random throttle, source gaps and data
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 3);
      throttle_en = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      s0 = n_sent;
      case (kind)
        0: begin
          send_frame(1'b1, -1, -1, 0, 1'b0, c);
          exp_frames += 1; exp_crc = c;
        end
        1: begin
          send_junk($urandom_range(1, 15));
          send_frame(1'b1, -1, -1, 0, 1'b0, c);
          exp_frames += 1; exp_crc = c;
        end
        2: begin
          send_frame(1'b1, -1, -1, $urandom_range(1, W * H - 1), 1'b0, dummy);
          send_frame(1'b1, -1, -1, 0, 1'b0, c);
          exp_frames += 1; exp_crc = c; exp_sof += 1; exp_sticky = 1'b1;
        end
        default: begin
          send_frame(1'b1, $urandom_range(0, H - 2), $urandom_range(0, W - 2), 0, 1'b0, dummy);
          exp_eol += 1; exp_sticky = 1'b1;
        end
      endcase
      exp_beats += 32'(n_sent - s0);
      check_state($sformatf("rnd%0d_k%0d", i, kind));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
